// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Contents: FSM state enum, opcode and funct constants, ALU control codes,
// ALU operation classes used by the ALU decoder, and the alu_src_b / pc_src
// mux encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operation class requested by the main FSM; FUNCT defers to the funct field.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder, shared with the single-cycle control path.
// Ports:
//   alu_op      in  2 - operation class (ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT)
//   funct       in  6 - instruction[5:0]
//   alu_ctrl    out 3 - ALU operation code
//   funct_valid out 1 - funct is one of the supported R-type functions,
//                       independent of alu_op so it can be used at decode time
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  logic [2:0] funct_ctrl;

  always_comb begin
    funct_ctrl  = ALU_ADD;
    funct_valid = 1'b0;
    case (funct)
      FN_ADD: begin funct_ctrl = ALU_ADD; funct_valid = 1'b1; end
      FN_SUB: begin funct_ctrl = ALU_SUB; funct_valid = 1'b1; end
      FN_AND: begin funct_ctrl = ALU_AND; funct_valid = 1'b1; end
      FN_OR:  begin funct_ctrl = ALU_OR;  funct_valid = 1'b1; end
      FN_SLT: begin funct_ctrl = ALU_SLT; funct_valid = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: alu_ctrl = funct_ctrl;
      default:     alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback for add/sub/and/or/slt, lw, sw, beq, addi, j.
// Outputs are Moore decodes of the state register, except pc_en (uses
// zero_flag in BEQEX), alu_ctrl (uses funct in RTYPEEX) and illegal (uses
// opcode/funct in DECODE, the first cycle they are valid).
// Ports:
//   clk, rst_n                - clock, async active-low reset
//   opcode, funct, zero_flag  - instruction fields and ALU zero result
//   iord, mem_write, ir_write - memory address select / write / IR load
//   reg_dst, mem_to_reg, reg_write - register file controls
//   alu_src_a, alu_src_b, alu_ctrl - ALU operand selects and operation
//   pc_src, pc_en             - next-PC select and PC load enable
//   instr_done, illegal       - last-state pulse / unsupported instruction pulse
//   state                     - current FSM state, for debug
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic [2:0] dec_ctrl;
  logic       funct_valid;
  logic       decode_illegal;

  // Un-gated strobes; reset masks them below.
  logic       pc_write;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       instr_done_raw;
  logic       alu_used;

  mips_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_ctrl    (dec_ctrl),
    .funct_valid (funct_valid)
  );

  // Next-state logic
  always_comb begin
    state_d        = S_FETCH;
    decode_illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid) state_d = S_RTYPEEX;
            else             decode_illegal = 1'b1;
          end
          OP_BEQ:  state_d = S_BEQEX;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JEX;
          default: decode_illegal = 1'b1;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Moore output decode
  always_comb begin
    iord           = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write_raw  = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = SRCB_REG;
    alu_op         = ALUOP_ADD;
    alu_used       = 1'b0;
    pc_src         = PCSRC_ALU;
    pc_write       = 1'b0;
    branch         = 1'b0;
    instr_done_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
        alu_src_b    = SRCB_FOUR;
        alu_used     = 1'b1;
      end
      S_DECODE: begin
        // Branch target precompute while the opcode is decoded.
        alu_src_b = SRCB_IMM_SH2;
        alu_used  = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_used  = 1'b1;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg     = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_MEMWR: begin
        iord           = 1'b1;
        mem_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        alu_used  = 1'b1;
      end
      S_RTYPEWB: begin
        reg_write_raw  = 1'b1;
        reg_dst        = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a      = 1'b1;
        alu_op         = ALUOP_SUB;
        alu_used       = 1'b1;
        branch         = 1'b1;
        pc_src         = PCSRC_ALUOUT;
        instr_done_raw = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_used  = 1'b1;
      end
      S_ADDIWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_JEX: begin
        pc_src         = PCSRC_JUMP;
        pc_write       = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // States that do not drive the ALU report operation code 000.
  assign alu_ctrl = alu_used ? dec_ctrl : 3'b000;

  // Reset masks every strobe combinationally so an abandoned instruction
  // cannot leave a partial write behind.
  assign ir_write   = rst_n & ir_write_raw;
  assign mem_write  = rst_n & mem_write_raw;
  assign reg_write  = rst_n & reg_write_raw;
  assign instr_done = rst_n & instr_done_raw;
  assign pc_en      = rst_n & (pc_write | (branch & zero_flag));
  assign illegal    = rst_n & (state_q == S_DECODE) & decode_illegal;
  assign state      = state_q;

endmodule
